axi_wr_burst_slave: RTL and testbench
=====================================

// Module: axi_wr_burst_slave
// PURPOSE
//  AXI4 write-side slave that terminates the AW/W/B channels driven by the axi_protocol master FSM.
//  Accepts one burst at a time and generates per-beat addresses for FIXED, INCR and WRAP bursts.
//  Drives a simple registered memory write port and returns one B response per burst.
// PARAMETERS
//  AW   32  address width
//  DW   64  data width; strobe width is DW/8; max legal awsize is log2(DW/8)=3
// PORTS
//  axi_aclk   in   1      clock
//  rst        in   1      reset, synchronous, active-high
//  s_awaddr   in   AW     burst start address
//  s_awlen    in   8      beats-1
//  s_awsize   in   3      log2 bytes per beat
//  s_awburst  in   2      00 FIXED, 01 INCR, 10 WRAP, 11 reserved
//  s_awvalid  in   1      AW valid
//  s_awready  out  1      AW ready
//  s_wdata    in   DW     write data
//  s_wstrb    in   DW/8   byte strobes
//  s_wlast    in   1      master's last-beat marker
//  s_wvalid   in   1      W valid
//  s_wready   out  1      W ready
//  s_bresp    out  2      00 OKAY, 10 SLVERR
//  s_bvalid   out  1      B valid
//  s_bready   in   1      B ready
//  mem_we     out  1      one-cycle write pulse
//  mem_addr   out  AW     beat address
//  mem_wdata  out  DW     beat data
//  mem_wstrb  out  DW/8   beat strobes
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, beat_cnt 0. Outputs are registered.
//  s_awready is 1 from the first cycle after rst deasserts.
//  FSM IDLE:
//   - s_awready=1, s_wready=0.
//   - On AW handshake: capture addr/len/size/burst; clear err; s_awready<=0; s_wready<=1; go DATA.
//  FSM DATA:
//   - Each W handshake: mem_we/mem_addr/mem_wdata/mem_wstrb valid the next cycle (latency 1).
//   - Each W handshake also advances the address and increments beat_cnt.
//   - Burst ends on beat count: the handshake with beat_cnt==len ends the burst.
//   - At burst end: s_wready<=0; s_bvalid<=1; s_bresp<=err?10:00; go RESP.
//   - s_wlast is checked, not trusted: wlast=1 before the final beat, or wlast=0 on it, sets err.
//  FSM RESP:
//   - Hold s_bvalid/s_bresp stable until s_bready.
//   - On B handshake: s_bvalid<=0; s_awready<=1; go IDLE.
//   - Earliest next AW acceptance is the cycle after the B handshake.
//  Address step: inc = 1<<size; all address arithmetic is modulo 2^AW.
//   - FIXED: address unchanged.
//   - INCR: addr+inc; no 4KB boundary check.
//   - WRAP: mask=((len+1)<<size)-1; next=(addr&~mask)|((addr+inc)&mask).
//  Errors (err=1 -> SLVERR):
//   - size>log2(DW/8), burst==11, or WRAP with len not in {1,3,7,15}: err set at AW handshake.
//     All W beats are still accepted, mem_we is suppressed for the whole burst, burst 11 steps as INCR.
//   - wlast mismatch: beats are still written.
//  W channel: s_wready=0 outside DATA, so W beats that arrive before AW are stalled, never dropped.
//  AW is never accepted during DATA or RESP (one outstanding burst).
//  Simultaneous events: W handshake on the final beat plus bready=1 in the same cycle has no effect,
//   since bvalid rises only after that cycle.
//  Reset mid-burst: abort at once; no B response; no mem_we after the reset cycle; partial writes stand.
// TESTING
//  T1 INCR len0 size3 addr 0x100, one beat wstrb 0xFF wlast=1:
//     one mem_we at 0x100; bresp 00; bvalid 1 cycle after the W handshake.
//  T2 WRAP len3 size3 addr 0x38, 4 beats:
//     mem_addr 0x38,0x20,0x28,0x30; bresp 00.
//  T3 FIXED len2 size2 addr 0x40, wvalid toggled every other cycle:
//     three mem_we at 0x40, data in order; bresp 00.
//  T4 INCR len1, bready held low 5 cycles:
//     bvalid/bresp stable; awready 0 until the cycle after the B handshake.
//  T5a INCR len3 with wlast on beat 2: 4 writes; bresp 10.
//  T5b awsize=4: 0 mem_we; bresp 10.
//  T6 rst for 1 cycle after beat 2 of an INCR len7 burst:
//     outputs 0; no bvalid; awready 1 the next cycle; a new burst completes OKAY.

Source files
------------

// File: rtl/axi_wr_burst_slave.sv
// -----------------------------------------------------------------------------
// axi_wr_burst_slave
//
// AXI4 write-side slave that terminates the AW/W/B channels. One burst is
// handled at a time: the AW request is captured, every W beat is forwarded to a
// simple registered memory write port with its computed beat address, and a
// single B response closes the burst.
//
// Handshake rule (all three channels): a transfer happens on a rising edge of
// axi_aclk where both valid and ready are 1. This slave never makes its ready
// depend combinationally on valid; every ready/valid it drives is a register.
//
// Ports
//   axi_aclk    clock
//   rst         synchronous, active-high reset
//   s_awaddr    burst start address
//   s_awlen     number of beats minus one
//   s_awsize    log2 of bytes per beat (legal up to log2(DW/8))
//   s_awburst   00 FIXED, 01 INCR, 10 WRAP, 11 reserved
//   s_awvalid   / s_awready   AW channel handshake
//   s_wdata     write data
//   s_wstrb     byte strobes
//   s_wlast     master's last-beat marker (checked against the beat count)
//   s_wvalid    / s_wready    W channel handshake
//   s_bresp     00 OKAY, 10 SLVERR
//   s_bvalid    / s_bready    B channel handshake
//   mem_we      one-cycle write pulse, one cycle after each W handshake
//   mem_addr    beat address
//   mem_wdata   beat data
//   mem_wstrb   beat strobes
// -----------------------------------------------------------------------------
module axi_wr_burst_slave #(
  parameter int AW = 32,
  parameter int DW = 64
) (
  input  logic              axi_aclk,
  input  logic              rst,

  input  logic [AW-1:0]     s_awaddr,
  input  logic [7:0]        s_awlen,
  input  logic [2:0]        s_awsize,
  input  logic [1:0]        s_awburst,
  input  logic              s_awvalid,
  output logic              s_awready,

  input  logic [DW-1:0]     s_wdata,
  input  logic [DW/8-1:0]   s_wstrb,
  input  logic              s_wlast,
  input  logic              s_wvalid,
  output logic              s_wready,

  output logic [1:0]        s_bresp,
  output logic              s_bvalid,
  input  logic              s_bready,

  output logic              mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [DW-1:0]     mem_wdata,
  output logic [DW/8-1:0]   mem_wstrb
);

  localparam int SW       = DW / 8;
  localparam int MAX_SIZE = $clog2(SW);

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // IDLE: waiting for AW. DATA: collecting beats. RESP: B response pending.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state;

  // Captured burst context
  logic [AW-1:0] addr;       // address of the next beat to be accepted
  logic [7:0]    len;
  logic [2:0]    size;
  logic [1:0]    burst;
  logic [7:0]    beat_cnt;   // beats accepted so far in this burst
  logic          err;        // burst will answer SLVERR
  logic          suppress;   // AW-time error: beats are swallowed, not written

  // Decoded events
  logic          aw_hs;
  logic          w_hs;
  logic          b_hs;
  logic          last_beat;
  logic          wlast_bad;
  logic          aw_bad;

  // Address stepping
  logic [AW-1:0] inc;
  logic [AW-1:0] wrap_mask;
  logic [AW-1:0] next_addr;

  assign aw_hs     = s_awvalid & s_awready;
  assign w_hs      = s_wvalid & s_wready;
  assign b_hs      = s_bvalid & s_bready;

  // The beat count, not s_wlast, decides where the burst ends.
  assign last_beat = (beat_cnt == len);
  assign wlast_bad = (s_wlast != last_beat);

  // Requests we cannot serve correctly still run to completion so the master
  // is never left hanging; they are only flagged here.
  assign aw_bad = (s_awsize > 3'(MAX_SIZE))
                | (s_awburst == BURST_RSVD)
                | ((s_awburst == BURST_WRAP) &&
                   !(s_awlen inside {8'd1, 8'd3, 8'd7, 8'd15}));

  // Next beat address. All arithmetic wraps modulo 2^AW. The reserved burst
  // type falls through to the INCR step.
  always_comb begin
    inc       = AW'(1) << size;
    wrap_mask = ((AW'(len) + AW'(1)) << size) - AW'(1);
    next_addr = addr + inc;
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_WRAP:  next_addr = (addr & ~wrap_mask) | ((addr + inc) & wrap_mask);
      default:     next_addr = addr + inc;
    endcase
  end

  always_ff @(posedge axi_aclk) begin
    if (rst) begin
      state     <= IDLE;
      addr      <= '0;
      len       <= '0;
      size      <= '0;
      burst     <= '0;
      beat_cnt  <= '0;
      err       <= 1'b0;
      suppress  <= 1'b0;
      s_awready <= 1'b0;
      s_wready  <= 1'b0;
      s_bvalid  <= 1'b0;
      s_bresp   <= RESP_OKAY;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
    end else begin
      // mem_we is a pulse; it is raised only in the cycle after a W handshake.
      mem_we <= 1'b0;

      case (state)
        IDLE: begin
          // awready comes up on the first cycle out of reset and stays up
          // until a request is taken.
          s_awready <= 1'b1;
          s_wready  <= 1'b0;
          if (aw_hs) begin
            addr      <= s_awaddr;
            len       <= s_awlen;
            size      <= s_awsize;
            burst     <= s_awburst;
            beat_cnt  <= '0;
            err       <= aw_bad;
            suppress  <= aw_bad;
            s_awready <= 1'b0;
            s_wready  <= 1'b1;
            state     <= DATA;
          end
        end

        DATA: begin
          if (w_hs) begin
            mem_we    <= ~suppress;
            mem_addr  <= addr;
            mem_wdata <= s_wdata;
            mem_wstrb <= s_wstrb;
            addr      <= next_addr;
            beat_cnt  <= beat_cnt + 8'd1;
            if (last_beat) begin
              // A wrong wlast on the final beat itself must still reach the
              // response, so it is folded in directly rather than via err.
              s_wready <= 1'b0;
              s_bvalid <= 1'b1;
              s_bresp  <= (err | wlast_bad) ? RESP_SLVERR : RESP_OKAY;
              beat_cnt <= '0;
              state    <= RESP;
            end else if (wlast_bad) begin
              err <= 1'b1;
            end
          end
        end

        RESP: begin
          // bvalid/bresp hold until the master takes the response.
          if (b_hs) begin
            s_bvalid  <= 1'b0;
            s_awready <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_wr_burst_slave.sv
// -----------------------------------------------------------------------------
// Bench for axi_wr_burst_slave: directed bursts with hand-computed expectations
// followed by randomized bursts, all checked every cycle against a
// transaction-level reference model.
// -----------------------------------------------------------------------------
module tb_axi_wr_burst_slave;

  localparam int AW  = 32;
  localparam int DW  = 64;
  localparam int SW  = DW / 8;
  localparam int TMO = 200;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic axi_aclk;
  logic rst;

  initial axi_aclk = 1'b0;
  always #5 axi_aclk = ~axi_aclk;

  // ---------------------------------------------------------------------------
  // DUT
  // ---------------------------------------------------------------------------
  logic [AW-1:0] s_awaddr;
  logic [7:0]    s_awlen;
  logic [2:0]    s_awsize;
  logic [1:0]    s_awburst;
  logic          s_awvalid;
  logic          s_awready;
  logic [DW-1:0] s_wdata;
  logic [SW-1:0] s_wstrb;
  logic          s_wlast;
  logic          s_wvalid;
  logic          s_wready;
  logic [1:0]    s_bresp;
  logic          s_bvalid;
  logic          s_bready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [SW-1:0] mem_wstrb;

  axi_wr_burst_slave #(.AW(AW), .DW(DW)) dut (
    .axi_aclk  (axi_aclk),
    .rst       (rst),
    .s_awaddr  (s_awaddr),
    .s_awlen   (s_awlen),
    .s_awsize  (s_awsize),
    .s_awburst (s_awburst),
    .s_awvalid (s_awvalid),
    .s_awready (s_awready),
    .s_wdata   (s_wdata),
    .s_wstrb   (s_wstrb),
    .s_wlast   (s_wlast),
    .s_wvalid  (s_wvalid),
    .s_wready  (s_wready),
    .s_bresp   (s_bresp),
    .s_bvalid  (s_bvalid),
    .s_bready  (s_bready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard bookkeeping
  // ---------------------------------------------------------------------------
  int vectors    = 0;
  int miscompares = 0;

  logic [DW-1:0] exp_q[$];       // data driven on W, in handshake order
  logic [AW-1:0] obs_addr_q[$];  // addresses seen on the memory port
  logic [DW-1:0] obs_data_q[$];  // data seen on the memory port
  logic [1:0]    last_bresp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: no handshake within %0d cycles (t=%0t)", name, TMO, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model helpers
  // ---------------------------------------------------------------------------
  // Address of beat idx of a burst, computed directly from the beat index.
  function automatic logic [AW-1:0] beat_addr(input logic [AW-1:0] start, input int len,
                                              input int size, input int btype, input int idx);
    longint unsigned s, inc, span, base, off;
    s   = 64'(start);
    inc = 64'd1 << size;
    if (btype == 0) return start;
    if (btype == 2) begin
      span = (64'(len) + 64'd1) * inc;
      base = s - (s % span);
      off  = (s - base + 64'(idx) * inc) % span;
      return AW'(base + off);
    end
    return AW'(s + 64'(idx) * inc);
  endfunction

  function automatic bit req_bad(input int len, input int size, input int btype);
    if (size > 3) return 1'b1;
    if (btype == 3) return 1'b1;
    if (btype == 2 && !(len == 1 || len == 3 || len == 7 || len == 15)) return 1'b1;
    return 1'b0;
  endfunction

  // ---------------------------------------------------------------------------
  // Reference model: tracks the open transaction and what every output must
  // show in the cycle after each edge.
  // ---------------------------------------------------------------------------
  bit            model_live = 1'b0;
  logic          exp_awready, exp_wready, exp_bvalid, exp_we, exp_zero;
  logic [1:0]    exp_bresp;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_wdata;
  logic [SW-1:0] exp_wstrb;

  logic [AW-1:0] m_start;
  int            m_len, m_size, m_type, m_idx;
  bit            m_bad, m_wlast_seen_early;

  always @(posedge axi_aclk) begin
    model_live <= 1'b1;
    if (rst) begin
      exp_awready <= 1'b0;
      exp_wready  <= 1'b0;
      exp_bvalid  <= 1'b0;
      exp_bresp   <= 2'b00;
      exp_we      <= 1'b0;
      exp_addr    <= '0;
      exp_wdata   <= '0;
      exp_wstrb   <= '0;
      exp_zero    <= 1'b1;
      m_idx       <= 0;
    end else begin
      exp_zero <= 1'b0;
      exp_we   <= 1'b0;

      if (exp_awready && s_awvalid) begin
        m_start            <= s_awaddr;
        m_len              <= int'(s_awlen);
        m_size             <= int'(s_awsize);
        m_type             <= int'(s_awburst);
        m_bad              <= req_bad(int'(s_awlen), int'(s_awsize), int'(s_awburst));
        m_wlast_seen_early <= 1'b0;
        m_idx              <= 0;
        exp_awready        <= 1'b0;
        exp_wready         <= 1'b1;
      end else if (!exp_wready && !exp_bvalid) begin
        exp_awready <= 1'b1;
      end

      if (exp_wready && s_wvalid) begin
        exp_we    <= !m_bad;
        exp_addr  <= beat_addr(m_start, m_len, m_size, m_type == 3 ? 1 : m_type, m_idx);
        exp_wdata <= s_wdata;
        exp_wstrb <= s_wstrb;
        m_idx     <= m_idx + 1;
        if (m_idx == m_len) begin
          exp_wready <= 1'b0;
          exp_bvalid <= 1'b1;
          exp_bresp  <= (m_bad || m_wlast_seen_early || !s_wlast) ? 2'b10 : 2'b00;
        end else if (s_wlast) begin
          m_wlast_seen_early <= 1'b1;
        end
      end

      if (exp_bvalid && s_bready) begin
        exp_bvalid  <= 1'b0;
        exp_awready <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Compare process (falling edge, away from the active edge)
  // ---------------------------------------------------------------------------
  always @(negedge axi_aclk) begin
    if (model_live) begin
      check("awready", 64'(s_awready), 64'(exp_awready));
      check("wready",  64'(s_wready),  64'(exp_wready));
      check("bvalid",  64'(s_bvalid),  64'(exp_bvalid));
      check("mem_we",  64'(mem_we),    64'(exp_we));
      if (exp_bvalid || exp_zero)
        check("bresp", 64'(s_bresp), 64'(exp_bresp));
      if (exp_we || exp_zero) begin
        check("mem_addr",  64'(mem_addr),  64'(exp_addr));
        check("mem_wdata", 64'(mem_wdata), 64'(exp_wdata));
        check("mem_wstrb", 64'(mem_wstrb), 64'(exp_wstrb));
      end
      if (mem_we === 1'b1) begin
        obs_addr_q.push_back(mem_addr);
        obs_data_q.push_back(mem_wdata);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (called at an active edge + 1)
  // ---------------------------------------------------------------------------
  task automatic drive_aw(input logic [AW-1:0] a, input int len, input int size,
                          input int btype, input int delay);
    int n;
    repeat (delay) begin @(posedge axi_aclk); #1; end
    s_awaddr  = a;
    s_awlen   = 8'(len);
    s_awsize  = 3'(size);
    s_awburst = 2'(btype);
    s_awvalid = 1'b1;
    n = 0;
    do begin @(posedge axi_aclk); n++; end while (!s_awready && n < TMO);
    if (!s_awready) timeout("aw_handshake");
    #1 s_awvalid = 1'b0;
  endtask

  task automatic send_beats(input int n_beats, input int last_pos,
                            input int gap_lo, input int gap_hi, input bit full_strb);
    int n;
    for (int i = 0; i < n_beats; i++) begin
      repeat ($urandom_range(gap_hi, gap_lo)) begin @(posedge axi_aclk); #1; end
      s_wdata  = {$urandom, $urandom};
      s_wstrb  = full_strb ? '1 : SW'($urandom);
      s_wlast  = (i == last_pos);
      s_wvalid = 1'b1;
      n = 0;
      do begin @(posedge axi_aclk); n++; end while (!s_wready && n < TMO);
      if (!s_wready) timeout("w_handshake");
      exp_q.push_back(s_wdata);
      #1;
      s_wvalid = 1'b0;
      s_wlast  = 1'b0;
    end
  endtask

  task automatic recv_b(input int delay);
    int n;
    repeat (delay) begin @(posedge axi_aclk); #1; end
    s_bready = 1'b1;
    n = 0;
    do begin @(posedge axi_aclk); n++; end while (!s_bvalid && n < TMO);
    if (!s_bvalid) timeout("b_handshake");
    last_bresp = s_bresp;
    #1 s_bready = 1'b0;
  endtask

  task automatic clear_logs();
    exp_q.delete();
    obs_addr_q.delete();
    obs_data_q.delete();
  endtask

  // One full burst: AW and W start together so early W beats get stalled.
  task automatic burst(input logic [AW-1:0] a, input int len, input int size, input int btype,
                       input int last_pos, input int aw_delay, input int gap_lo, input int gap_hi,
                       input int b_delay);
    fork
      drive_aw(a, len, size, btype, aw_delay);
      send_beats(len + 1, last_pos, gap_lo, gap_hi, 1'b0);
    join
    recv_b(b_delay);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  logic [AW-1:0] t2_exp [4];

  initial begin
    int len, size, btype, last_pos;
    bit early;

    rst       = 1'b1;
    s_awaddr  = '0;
    s_awlen   = '0;
    s_awsize  = '0;
    s_awburst = '0;
    s_awvalid = 1'b0;
    s_wdata   = '0;
    s_wstrb   = '0;
    s_wlast   = 1'b0;
    s_wvalid  = 1'b0;
    s_bready  = 1'b0;
    last_bresp = 2'b11;
    t2_exp[0] = 32'h38;
    t2_exp[1] = 32'h20;
    t2_exp[2] = 32'h28;
    t2_exp[3] = 32'h30;

    repeat (3) @(posedge axi_aclk);
    #1 rst = 1'b0;

    // Reset state
    check("rst_awready", 64'(s_awready), 64'd0);
    check("rst_bvalid",  64'(s_bvalid),  64'd0);
    check("rst_mem_we",  64'(mem_we),    64'd0);
    @(posedge axi_aclk); #1;
    check("awready_after_rst", 64'(s_awready), 64'd1);

    // T1: INCR len0 size3 @0x100, single full-strobe beat
    clear_logs();
    fork
      drive_aw(32'h100, 0, 3, 1, 0);
      send_beats(1, 0, 0, 0, 1'b1);
    join
    check("t1_bvalid_latency", 64'(s_bvalid), 64'd1);
    check("t1_wstrb", 64'(mem_wstrb), 64'hFF);
    recv_b(0);
    check("t1_nwrites", 64'(obs_addr_q.size()), 64'd1);
    if (obs_addr_q.size() > 0) check("t1_addr", 64'(obs_addr_q[0]), 64'h100);
    check("t1_bresp", 64'(last_bresp), 64'd0);

    // T2: WRAP len3 size3 @0x38
    clear_logs();
    burst(32'h38, 3, 3, 2, 3, 0, 0, 0, 0);
    check("t2_nwrites", 64'(obs_addr_q.size()), 64'd4);
    for (int i = 0; i < 4; i++)
      check($sformatf("t2_addr%0d", i),
            (i < obs_addr_q.size()) ? 64'(obs_addr_q[i]) : 64'hDEAD, 64'(t2_exp[i]));
    check("t2_bresp", 64'(last_bresp), 64'd0);

    // T3: FIXED len2 size2 @0x40, wvalid every other cycle
    clear_logs();
    burst(32'h40, 2, 2, 0, 2, 0, 1, 1, 0);
    check("t3_nwrites", 64'(obs_addr_q.size()), 64'd3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t3_addr%0d", i),
            (i < obs_addr_q.size()) ? 64'(obs_addr_q[i]) : 64'hDEAD, 64'h40);
      check($sformatf("t3_data%0d", i),
            (i < obs_data_q.size()) ? obs_data_q[i] : 64'hDEAD, exp_q[i]);
    end
    check("t3_bresp", 64'(last_bresp), 64'd0);

    // T4: INCR len1, bready held off 5 cycles
    clear_logs();
    burst(32'h200, 1, 3, 1, 1, 0, 0, 0, 5);
    check("t4_nwrites", 64'(obs_addr_q.size()), 64'd2);
    check("t4_bresp", 64'(last_bresp), 64'd0);

    // T5a: INCR len3 with wlast on the second beat
    clear_logs();
    burst(32'h300, 3, 3, 1, 1, 0, 0, 0, 0);
    check("t5a_nwrites", 64'(obs_addr_q.size()), 64'd4);
    check("t5a_bresp", 64'(last_bresp), 64'd2);

    // T5b: illegal awsize
    clear_logs();
    burst(32'h400, 2, 4, 1, 2, 0, 0, 0, 0);
    check("t5b_nwrites", 64'(obs_addr_q.size()), 64'd0);
    check("t5b_bresp", 64'(last_bresp), 64'd2);

    // T6: reset after two beats of an INCR len7 burst
    clear_logs();
    fork
      drive_aw(32'h500, 7, 3, 1, 0);
      send_beats(2, -1, 0, 0, 1'b0);
    join
    rst = 1'b1;
    @(posedge axi_aclk); #1;
    rst = 1'b0;
    check("t6_wready",  64'(s_wready),  64'd0);
    check("t6_bvalid",  64'(s_bvalid),  64'd0);
    check("t6_awready", 64'(s_awready), 64'd0);
    check("t6_mem_we",  64'(mem_we),    64'd0);
    @(posedge axi_aclk); #1;
    check("t6_awready_next", 64'(s_awready), 64'd1);
    check("t6_partial_writes", 64'(obs_addr_q.size()), 64'd2);
    clear_logs();
    burst(32'h600, 2, 3, 1, 2, 0, 0, 1, 0);
    check("t6_new_nwrites", 64'(obs_addr_q.size()), 64'd3);
    check("t6_new_bresp", 64'(last_bresp), 64'd0);

    // Randomized bursts
    for (int t = 0; t < 40; t++) begin
      btype = ($urandom_range(9, 0) == 0) ? 3 : int'($urandom_range(2, 0));
      size  = ($urandom_range(9, 0) == 0) ? int'($urandom_range(7, 4)) : int'($urandom_range(3, 0));
      if (btype == 2 && $urandom_range(9, 0) != 0) begin
        case ($urandom_range(3, 0))
          0: len = 1;
          1: len = 3;
          2: len = 7;
          default: len = 15;
        endcase
      end else if ($urandom_range(19, 0) == 0) begin
        len = int'($urandom_range(63, 0));
      end else begin
        len = int'($urandom_range(15, 0));
      end
      last_pos = ($urandom_range(9, 0) == 0) ? int'($urandom_range(len + 1, 0)) : len;
      early = ($urandom_range(3, 0) == 0);
      if (early) s_bready = 1'b1;
      burst($urandom, len, size, btype, last_pos, int'($urandom_range(3, 0)), 0, 2,
            early ? 0 : int'($urandom_range(3, 0)));
    end

    repeat (3) @(posedge axi_aclk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global time limit
  initial begin
    #500000;
    miscompares++;
    $display("FAIL watchdog: simulation did not complete, time=%0t", $time);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
